// File: rtl/snn_fc_pkg.sv
// rtl/snn_fc_pkg.sv - shared types, FSM encoding and saturating add for the FC LIF core
//
// Purpose: common widths (weight w_t, membrane pot_t), the controller state
//          encoding and the symmetric saturating adder used by every lane.
// Ports:   none (package).
package snn_fc_pkg;

  localparam int W_WIDTH   = 8;   // signed weight/bias, Q8
  localparam int POT_WIDTH = 16;  // signed membrane, Q8

  typedef logic signed [W_WIDTH-1:0]   w_t;
  typedef logic signed [POT_WIDTH-1:0] pot_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    BIAS_RD = 2'd2,
    FIRE    = 2'd3
  } fsm_state_t;

  localparam int POT_MAX_I = 2**(POT_WIDTH-1) - 1;
  localparam pot_t POT_MAX = pot_t'(POT_MAX_I);
  localparam pot_t POT_MIN = -POT_MAX;
  localparam logic signed [POT_WIDTH:0] SUM_MAX = (POT_WIDTH+1)'(POT_MAX_I);
  localparam logic signed [POT_WIDTH:0] SUM_MIN = -SUM_MAX;

  // Symmetric clamp: the most negative code is never produced, so the
  // membrane range stays +/-(2^(POT_WIDTH-1)-1).
  function automatic pot_t sat_add(input pot_t a, input pot_t b);
    logic signed [POT_WIDTH:0] s;
    s = {a[POT_WIDTH-1], a} + {b[POT_WIDTH-1], b};
    if (s > SUM_MAX)
      return POT_MAX;
    else if (s < SUM_MIN)
      return POT_MIN;
    else
      return s[POT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fc_lif_lane.sv
// rtl/fc_lif_lane.sv - one lane of the LIF datapath (add, threshold, reset, leak)
//
// Purpose: purely combinational lane datapath. o_sum is the saturated
//          membrane-plus-word sum, used as the accumulate result while spikes
//          arrive and as v (membrane plus bias) in the fire cycle.
// Ports:   i_pot   current membrane of this lane's neuron
//          i_w     weight or bias word for this lane
//          o_sum   sat(i_pot + sign-extended i_w)
//          o_spike o_sum strictly above THRESHOLD
//          o_next  post-spike reset then leak: v1 - (v1 >>> BETA_SHIFT)
module fc_lif_lane import snn_fc_pkg::*; #(
  parameter int THRESHOLD      = 256,
  parameter int BETA_SHIFT     = 3,
  parameter int RESET_SUBTRACT = 1
) (
  input  pot_t i_pot,
  input  w_t   i_w,
  output pot_t o_sum,
  output logic o_spike,
  output pot_t o_next
);

  localparam pot_t THR = pot_t'(THRESHOLD);

  pot_t w_wext;
  pot_t w_v1;

  assign w_wext  = pot_t'(i_w);  // signed cast sign-extends
  assign o_sum   = sat_add(i_pot, w_wext);
  assign o_spike = (o_sum > THR);

  always_comb begin
    w_v1 = o_sum;
    if (o_spike)
      w_v1 = (RESET_SUBTRACT != 0) ? (o_sum - THR) : '0;
  end

  // >>> on a signed operand keeps the leak symmetric for negative membranes
  assign o_next = w_v1 - (w_v1 >>> BETA_SHIFT);

endmodule

// File: rtl/fc_nc_array.sv
// rtl/fc_nc_array.sv - fully-connected LIF neuron core, LANES neurons per group
//
// Purpose: per timestep and group, accumulates one weight word per accepted
//          spike address, adds the group bias, fires and leaks; membranes for
//          all groups are held here across timesteps.
// Config:  define SPK_CNT_EN to add saturating per-neuron spike counters and
//          the o_spk_cnt port.
// Ports:   i_clk, i_rst (sync, active high)
//          i_start, i_group, i_last_time_step  timestep request, taken in IDLE
//          i_spk_valid, i_spk_addr, o_spk_ready spike address handshake
//          i_accum_done                        last spike of the timestep seen
//          o_bram_ren, o_bram_raddr, i_bram_rdat weight memory, 1-cycle latency
//          o_out_valid, o_out_spk              per-group spike result pulse
//          o_spk_cnt (SPK_CNT_EN)              spike counts with o_out_valid
//          o_busy                              controller not idle
module fc_nc_array import snn_fc_pkg::*; #(
  parameter int LANES            = 4,
  parameter int IN_CHANNELS      = 2,
  parameter int INPUT_FRAME_SIZE = 28,
  parameter int LAYER_SIZE       = 10,
  parameter int THRESHOLD        = 256,
  parameter int BETA_SHIFT       = 3,
  parameter int RESET_SUBTRACT   = 1,
  parameter int BRAM_ADDR_WIDTH  = 10,
  parameter int CNT_WIDTH        = 8,
  localparam int FAN_IN  = IN_CHANNELS * INPUT_FRAME_SIZE,
  localparam int GROUPS  = (LAYER_SIZE + LANES - 1) / LANES,
  localparam int GRP_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int ADDR_W  = (FAN_IN > 1) ? $clog2(FAN_IN) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [GRP_W-1:0]             i_group,
  input  logic                         i_last_time_step,
  input  logic                         i_spk_valid,
  input  logic [ADDR_W-1:0]            i_spk_addr,
  output logic                         o_spk_ready,
  input  logic                         i_accum_done,
  output logic                         o_bram_ren,
  output logic [BRAM_ADDR_WIDTH-1:0]   o_bram_raddr,
  input  logic [LANES*W_WIDTH-1:0]     i_bram_rdat,
  output logic                         o_out_valid,
  output logic [LANES-1:0]             o_out_spk,
`ifdef SPK_CNT_EN
  output logic [LANES*CNT_WIDTH-1:0]   o_spk_cnt,
`endif
  output logic                         o_busy
);

  // Every group code gets storage so an out-of-range group cannot index
  // past the array; slots beyond LAYER_SIZE are never reported.
  localparam int NSLOT = (1 << GRP_W) * LANES;
  localparam int IDX_W = $clog2(NSLOT);
  localparam int ROW   = FAN_IN + 1;

  fsm_state_t        r_state;
  logic [GRP_W-1:0]  r_group;
  logic              r_last;
  logic              r_wv;         // read issued last cycle, word on i_bram_rdat now
  logic              r_out_valid;
  logic [LANES-1:0]  r_out_spk;
  pot_t              r_mem [NSLOT];

  logic                       w_hs;
  logic [BRAM_ADDR_WIDTH-1:0] w_base;
  logic [IDX_W-1:0]           w_idx  [LANES];
  pot_t                       w_sum  [LANES];
  pot_t                       w_next [LANES];
  logic [LANES-1:0]           w_spike;
  logic [LANES-1:0]           w_live;

  assign w_hs        = (r_state == ACCUM) && i_spk_valid;
  assign w_base      = BRAM_ADDR_WIDTH'(r_group) * BRAM_ADDR_WIDTH'(ROW);
  assign o_spk_ready = (r_state == ACCUM);
  assign o_busy      = (r_state != IDLE);
  assign o_bram_ren  = w_hs || (r_state == BIAS_RD);
  assign o_out_valid = r_out_valid;
  assign o_out_spk   = r_out_spk;

  always_comb begin
    o_bram_raddr = '0;
    if (r_state == BIAS_RD)
      o_bram_raddr = w_base + BRAM_ADDR_WIDTH'(FAN_IN);
    else if (w_hs)
      o_bram_raddr = w_base + BRAM_ADDR_WIDTH'(i_spk_addr);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_idx[l]  = IDX_W'(r_group) * IDX_W'(LANES) + IDX_W'(l);
    assign w_live[l] = (int'(r_group) * LANES + l) < LAYER_SIZE;

    fc_lif_lane #(
      .THRESHOLD      (THRESHOLD),
      .BETA_SHIFT     (BETA_SHIFT),
      .RESET_SUBTRACT (RESET_SUBTRACT)
    ) u_lane (
      .i_pot   (r_mem[w_idx[l]]),
      .i_w     (i_bram_rdat[l*W_WIDTH +: W_WIDTH]),
      .o_sum   (w_sum[l]),
      .o_spike (w_spike[l]),
      .o_next  (w_next[l])
    );
  end

  // The last weight read can still be in flight in BIAS_RD; it lands before
  // FIRE, and nothing is read in BIAS_RD's data slot, so r_wv is never set
  // in FIRE and the two membrane writes cannot collide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_group     <= '0;
      r_last      <= 1'b0;
      r_wv        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_spk   <= '0;
      for (int i = 0; i < NSLOT; i++)
        r_mem[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_wv        <= w_hs;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= ACCUM;
            r_group <= i_group;
            r_last  <= i_last_time_step;
          end
        end
        ACCUM:   if (i_accum_done) r_state <= BIAS_RD;
        BIAS_RD: r_state <= FIRE;
        FIRE: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b1;
          r_out_spk   <= w_spike & w_live;
        end
        default: r_state <= IDLE;
      endcase
      for (int l = 0; l < LANES; l++) begin
        if (r_wv)
          r_mem[w_idx[l]] <= w_sum[l];
        else if (r_state == FIRE)
          r_mem[w_idx[l]] <= r_last ? '0 : w_next[l];
      end
    end
  end

`ifdef SPK_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0]       r_cnt [NSLOT];
  logic [LANES*CNT_WIDTH-1:0] r_cnt_out;
  logic [CNT_WIDTH-1:0]       w_cnt_new [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_cnt
    assign w_cnt_new[l] = (w_spike[l] && w_live[l] && (r_cnt[w_idx[l]] != CNT_MAX))
                          ? r_cnt[w_idx[l]] + 1'b1 : r_cnt[w_idx[l]];
  end

  // Counts are reported including this timestep's spike, then cleared on
  // the last timestep so the next inference starts from zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt_out <= '0;
      for (int i = 0; i < NSLOT; i++)
        r_cnt[i] <= '0;
    end else if (r_state == FIRE) begin
      for (int l = 0; l < LANES; l++) begin
        r_cnt_out[l*CNT_WIDTH +: CNT_WIDTH] <= w_cnt_new[l];
        r_cnt[w_idx[l]] <= r_last ? '0 : w_cnt_new[l];
      end
    end
  end

  assign o_spk_cnt = r_cnt_out;
`endif

endmodule

// File: tb/tb_fc_nc_array.sv
// tb/tb_fc_nc_array.sv - randomized and directed bench for fc_nc_array
module tb_fc_nc_array;

  localparam int LANES = 4;
  localparam int ROW   = 57;
  localparam int NNEUR = 10;
  localparam int THR   = 256;

  logic        clk = 1'b0;
  logic        rst, start, last_ts, spk_valid, accum_done;
  logic [1:0]  group;
  logic [5:0]  spk_addr;
  logic        spk_ready, bram_ren, out_valid, busy;
  logic [9:0]  bram_raddr;
  logic [31:0] bram_rdat;
  logic [3:0]  out_spk;
`ifdef SPK_CNT_EN
  logic [31:0] spk_cnt;
`endif

  always #5 clk = ~clk;

  fc_nc_array dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .i_group          (group),
    .i_last_time_step (last_ts),
    .i_spk_valid      (spk_valid),
    .i_spk_addr       (spk_addr),
    .o_spk_ready      (spk_ready),
    .i_accum_done     (accum_done),
    .o_bram_ren       (bram_ren),
    .o_bram_raddr     (bram_raddr),
    .i_bram_rdat      (bram_rdat),
    .o_out_valid      (out_valid),
    .o_out_spk        (out_spk),
`ifdef SPK_CNT_EN
    .o_spk_cnt        (spk_cnt),
`endif
    .o_busy           (busy)
  );

  logic [31:0] wmem [1024];
  always @(posedge clk) if (bram_ren) bram_rdat <= wmem[bram_raddr];

  int total = 0;
  int bad   = 0;
  int mpot [12];
  int mcnt [12];
  int exp_cnt [4];
  logic [3:0] exp_spk;
  int q_addr [$];

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int x);
    if (x > 32767) return 32767;
    if (x < -32767) return -32767;
    return x;
  endfunction

  function automatic int wt(input int g, input int a, input int l);
    logic [31:0]       word;
    logic signed [7:0] b;
    word = wmem[g*ROW + a];
    b    = word[l*8 +: 8];
    return int'(b);
  endfunction

  // Reference timestep: sum weights, add bias, fire above threshold with
  // subtractive reset, leak by 1/8, or clear everything on the last step.
  task automatic model_step(input int g, input bit last);
    exp_spk = '0;
    for (int l = 0; l < LANES; l++) begin
      int nn, p, v;
      nn = g*LANES + l;
      p  = mpot[nn];
      foreach (q_addr[k]) p = clamp(p + wt(g, q_addr[k], l));
      v = clamp(p + wt(g, 56, l));
      if (v > THR) begin
        v = v - THR;
        if (nn < NNEUR) begin
          exp_spk[l] = 1'b1;
          if (mcnt[nn] < 255) mcnt[nn]++;
        end
      end
      mpot[nn]   = last ? 0 : v - (v >>> 3);
      exp_cnt[l] = mcnt[nn];
      if (last) mcnt[nn] = 0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 12; i++) begin
      mpot[i] = 0;
      mcnt[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic clear_wmem();
    for (int i = 0; i < 1024; i++) wmem[i] = '0;
  endtask

  // Called at #1 after an edge with the DUT idle.
  task automatic run_step(input int g, input bit last, input bit coinc, input bit poke);
    int  n;
    bit  seen;
    n = q_addr.size();
    model_step(g, last);
    start = 1'b1; group = 2'(g); last_ts = last;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_accum", busy, 1);
    for (int k = 0; k < n; k++) begin
      spk_valid  = 1'b1;
      spk_addr   = 6'(q_addr[k]);
      accum_done = coinc && (k == n-1);
      if (poke && k == 0) begin start = 1'b1; group = 2'(g ^ 1); end
      #1;
      check("spk_ready", spk_ready, 1);
      check("spk_raddr", bram_raddr, g*ROW + q_addr[k]);
      @(posedge clk); #1;
      start = 1'b0;
    end
    spk_valid = 1'b0;
    if (!coinc || n == 0) begin
      accum_done = 1'b1;
      if (poke && n == 0) begin start = 1'b1; group = 2'(g ^ 1); end
      @(posedge clk); #1;
      start = 1'b0;
    end
    accum_done = 1'b0;
    check("bias_ren", bram_ren, 1);
    check("bias_raddr", bram_raddr, g*ROW + 56);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("out_valid_seen", seen, 1);
    check("out_spk", out_spk, exp_spk);
`ifdef SPK_CNT_EN
    for (int l = 0; l < LANES; l++) check("spk_cnt", spk_cnt[l*8 +: 8], exp_cnt[l]);
`endif
    for (int l = 0; l < LANES; l++)
      if (g*LANES + l < NNEUR) check("pot", dut.r_mem[g*LANES + l], mpot[g*LANES + l]);
    @(posedge clk); #1;
    check("out_valid_pulse", out_valid, 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; last_ts = 1'b0; spk_valid = 1'b0; accum_done = 1'b0;
    group = '0; spk_addr = '0;
    clear_wmem();
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", spk_ready, 0);
    check("rst_ren", bram_ren, 0);
    check("rst_raddr", bram_raddr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_spk", out_spk, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single spike, weight 64, bias 0 -> 64 leaked to 56
    wmem[5] = {4{8'd64}};
    q_addr = '{5};
    run_step(0, 0, 0, 0);
    check("t1_pot", dut.r_mem[0], 56);

    // 4 x 100 -> v=400 fires, 144 leaked to 126
    do_reset(); clear_wmem();
    for (int a = 1; a <= 4; a++) wmem[a] = {4{8'd100}};
    q_addr = '{1, 2, 3, 4};
    run_step(0, 0, 1, 0);
    check("t2_pot", dut.r_mem[0], 126);
    check("t2_spk", out_spk, 15);

    // saturation both directions
    do_reset(); clear_wmem();
    wmem[ROW + 7]   = {4{8'd127}};
    wmem[2*ROW + 9] = {4{8'h81}};
    q_addr = {};
    for (int i = 0; i < 300; i++) q_addr.push_back(7);
    run_step(1, 0, 0, 0);
    check("sat_pos_pot", dut.r_mem[4], 28448);
    q_addr = {};
    for (int i = 0; i < 300; i++) q_addr.push_back(9);
    run_step(2, 0, 1, 0);
    check("sat_neg_pot", dut.r_mem[8], -28671);
    check("sat_neg_spk", out_spk, 0);

    // zero-spike last step clears group, next step reads back zero
    q_addr = {};
    run_step(1, 1, 0, 0);
    check("last_clr_pot", dut.r_mem[5], 0);
    run_step(1, 0, 0, 0);
    check("after_last_spk", out_spk, 0);
    check("after_last_pot", dut.r_mem[4], 0);

    // accum_done with last spike, plus a start while busy
    do_reset(); clear_wmem();
    for (int a = 1; a <= 3; a++) wmem[a] = {4{8'd100}};
    q_addr = '{1, 2, 3};
    run_step(0, 0, 1, 1);
    check("coinc_pot", dut.r_mem[0], 39);
    check("coinc_other_grp", dut.r_mem[4], 0);
`ifdef SPK_CNT_EN
    run_step(0, 0, 1, 0);
    run_step(0, 1, 0, 0);
    check("cnt_three", spk_cnt[7:0], 3);
    q_addr = {};
    run_step(0, 0, 0, 0);
    check("cnt_cleared", spk_cnt[7:0], 0);
`endif

    // reset mid-accumulation aborts the timestep
    start = 1'b1; group = 2'd0; last_ts = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    spk_valid = 1'b1; spk_addr = 6'd1;
    @(posedge clk); #1;
    spk_addr = 6'd2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_ready", spk_ready, 0);
    rst = 1'b0; spk_valid = 1'b0;
    clear_model();
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    check("abort_pot", dut.r_mem[0], 0);

    // randomized timesteps against the reference
    for (int i = 0; i < 3*ROW; i++) wmem[i] = $urandom;
    for (int it = 0; it < 40; it++) begin
      int g, n;
      g = $urandom_range(0, 2);
      n = $urandom_range(0, 8);
      q_addr = {};
      for (int k = 0; k < n; k++) q_addr.push_back($urandom_range(0, 55));
      run_step(g, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
